// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline control slice.
package pipe_hazard_ctrl_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [31:0] INST_NOP    = 32'h0000_0013;
   localparam logic [6:0]  OPC_LOAD    = 7'b000_0011;
   localparam logic [6:0]  OPC_STORE   = 7'b010_0011;
   localparam logic [6:0]  OPC_BRANCH  = 7'b110_0011;
   localparam logic [6:0]  OPC_JAL     = 7'b110_1111;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      LSU_WAIT = 2'd2,
      REDIRECT = 2'd3
   } hazard_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// Wrapping stall/flush event counters and the sticky LSU timeout flag.
module hazard_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_inc,
   input  logic             flush_inc,
   input  logic             err_set,
   input  logic             err_clr,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events,
   output logic             lsu_timeout_err
);

   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             err_q, err_d;

   // A set in the same cycle as a clear must leave the flag high.
   always_comb begin
      stall_d = stall_q + (stall_inc ? CNT_W'(1) : CNT_W'(0));
      flush_d = flush_q + (flush_inc ? CNT_W'(1) : CNT_W'(0));
      err_d   = err_set | (err_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
         err_q   <= 1'b0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
         err_q   <= err_d;
      end
   end

   assign stall_cycles    = stall_q;
   assign flush_events    = flush_q;
   assign lsu_timeout_err = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use, EX redirects, LSU waits and boot flush.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int LSU_TIMEOUT     = 255,
   parameter int REDIRECT_CYCLES = 1,
   parameter int CNT_W           = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic                  rs1_used_id,
   input  logic                  rs2_used_id,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic                  mem_read_ex,
   input  logic                  jump_en_ex,
   input  logic                  lsu_req_ex,
   input  logic                  lsu_ready,
   input  logic                  err_clr,
   output logic                  stall_n_pc,
   output logic                  stall_n_ifid,
   output logic                  stall_n_idex,
   output logic                  stall_n_exmem,
   output logic                  flush_ifid,
   output logic                  flush_idex,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_events,
   output logic                  lsu_timeout_err
);

   localparam int T_W = $clog2(LSU_TIMEOUT + 1);
   localparam int R_W = (REDIRECT_CYCLES < 1) ? 1 : $clog2(REDIRECT_CYCLES + 1);

   hazard_state_e  state_q, state_d;
   logic [T_W-1:0] timer_q, timer_d;
   logic [R_W-1:0] redir_q, redir_d;
   logic           err_set;
   logic           jump_take;
   logic           lsu_block;
   logic           load_use;

   assign lsu_block = lsu_req_ex & ~lsu_ready;
   assign load_use  = mem_read_ex & (rd_ex != '0) &
                      ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         timer_q <= '0;
         redir_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         redir_q <= redir_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      redir_d   = redir_q;
      err_set   = 1'b0;
      jump_take = 1'b0;
      case (state_q)
         BOOT: state_d = RUN;
         RUN, REDIRECT: begin
            if (lsu_block) begin
               state_d = LSU_WAIT;
               timer_d = T_W'(1);
            end else if (jump_en_ex) begin
               jump_take = 1'b1;
               redir_d   = R_W'(1);
               state_d   = (REDIRECT_CYCLES > 0) ? REDIRECT : RUN;
            end else if (state_q == REDIRECT) begin
               if (redir_q >= R_W'(REDIRECT_CYCLES)) state_d = RUN;
               else redir_d = redir_q + R_W'(1);
            end
         end
         LSU_WAIT: begin
            // The access is abandoned on timeout; EX must not replay it.
            if (lsu_ready) begin
               state_d = RUN;
            end else if (timer_q >= T_W'(LSU_TIMEOUT)) begin
               err_set = 1'b1;
               state_d = RUN;
            end else begin
               timer_d = timer_q + T_W'(1);
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_comb begin
      stall_n_pc    = 1'b1;
      stall_n_ifid  = 1'b1;
      stall_n_idex  = 1'b1;
      stall_n_exmem = 1'b1;
      flush_ifid    = 1'b0;
      flush_idex    = 1'b0;
      case (state_q)
         BOOT: begin
            stall_n_pc = 1'b0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
         end
         RUN, REDIRECT: begin
            if (lsu_block) begin
               stall_n_pc    = 1'b0;
               stall_n_ifid  = 1'b0;
               stall_n_idex  = 1'b0;
               stall_n_exmem = 1'b0;
            end else if (jump_en_ex) begin
               flush_ifid = 1'b1;
               flush_idex = 1'b1;
            end else if (state_q == REDIRECT) begin
               flush_ifid = 1'b1;
            end else if (load_use) begin
               stall_n_pc   = 1'b0;
               stall_n_ifid = 1'b0;
               flush_idex   = 1'b1;
            end
         end
         LSU_WAIT: begin
            stall_n_pc    = 1'b0;
            stall_n_ifid  = 1'b0;
            stall_n_idex  = 1'b0;
            stall_n_exmem = 1'b0;
         end
         default: ;
      endcase
   end

   hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall_inc       (~stall_n_pc),
      .flush_inc       (jump_take),
      .err_set         (err_set),
      .err_clr         (err_clr),
      .stall_cycles    (stall_cycles),
      .flush_events    (flush_events),
      .lsu_timeout_err (lsu_timeout_err)
   );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline control unit for the 5-stage RV32I core.
- Generates the stall_n and flush controls that the IF/ID, ID/EX and EX/MEM pipeline registers consume.
- Sources of control: load-use hazards, taken jumps/branches resolved in EX, multi-cycle data-memory waits, and the post-reset boot flush.
- Also keeps stall/flush performance counters and a sticky LSU-timeout error flag.

Parameters:
- LSU_TIMEOUT, 255: max consecutive LSU_WAIT cycles before abort; must be ≥1.
- REDIRECT_CYCLES, 1: extra cycles flush_ifid stays high after a taken jump, covering IMEM read latency; 0 allowed.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- rs1_id  in  5  rs1 index of instruction in ID.
- rs2_id  in  5  rs2 index of instruction in ID.
- rs1_used_id  in  1  ID instruction reads rs1.
- rs2_used_id  in  1  ID instruction reads rs2.
- rd_ex  in  5  destination of instruction in EX.
- mem_read_ex  in  1  EX instruction is a load.
- jump_en_ex  in  1  taken branch/jump resolved in EX.
- lsu_req_ex  in  1  EX/MEM issuing a data-memory access.
- lsu_ready  in  1  data memory accepted/completed the access this cycle.
- err_clr  in  1  clears lsu_timeout_err.
- stall_n_pc  out  1  0 holds PC.
- stall_n_ifid  out  1  0 holds IF/ID.
- stall_n_idex  out  1  0 holds ID/EX.
- stall_n_exmem  out  1  0 holds EX/MEM.
- flush_ifid  out  1  IF/ID loads NOP.
- flush_idex  out  1  ID/EX loads NOP.
- stall_cycles  out  CNT_W  count of cycles with stall_n_pc=0.
- flush_events  out  CNT_W  count of taken-jump flushes.
- lsu_timeout_err  out  1  sticky LSU timeout flag.

Behaviour:
- FSM states:
  - BOOT (reset state).
  - RUN.
  - LSU_WAIT.
  - REDIRECT.
- Control outputs are combinational from state and inputs, so they act in the same cycle.
- Counters, the error flag, the wait timer and the redirect counter are registered.
- Reset (async, rst_n=0):
  - state=BOOT; counters=0; lsu_timeout_err=0; internal timers=0.
  - Outputs while in BOOT: stall_n_pc=0, stall_n_ifid=1, stall_n_idex=1, stall_n_exmem=1, flush_ifid=1, flush_idex=1.
- BOOT:
  - Lasts exactly one clk edge after rst_n deasserts, then goes to RUN.
  - A reset asserted mid-operation in any state returns to BOOT immediately.
- RUN, evaluated in priority order (highest first):
  - 1. lsu_req_ex & !lsu_ready:
    - All stall_n=0; flush=0.
    - Next state LSU_WAIT; timer loads 1.
  - 2. jump_en_ex:
    - flush_ifid=1, flush_idex=1, all stall_n=1.
    - flush_events+1.
    - Next state REDIRECT if REDIRECT_CYCLES>0, else RUN.
    - Load-use in the same cycle is ignored because the ID instruction is flushed.
  - 3. Load-use, defined as mem_read_ex & rd_ex≠0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)):
    - stall_n_pc=0, stall_n_ifid=0, flush_idex=1 (bubble), stall_n_idex=1, stall_n_exmem=1.
    - Lasts one cycle only; the next cycle re-evaluates.
  - 4. Otherwise: all stall_n=1, flush=0.
- LSU_WAIT:
  - All stall_n=0 and no flushes while waiting.
  - lsu_ready=1: outputs in that cycle are all stall_n=0; next state RUN.
  - Timer reaches LSU_TIMEOUT with no ready: set lsu_timeout_err, next state RUN (the access is abandoned).
  - jump_en_ex is ignored in this state.
- REDIRECT:
  - flush_ifid=1, flush_idex=0, all stall_n=1.
  - Counter runs REDIRECT_CYCLES cycles, then RUN.
  - A new jump_en_ex restarts REDIRECT: flush_idex=1 that cycle, flush_events+1.
  - A new lsu_req_ex & !lsu_ready takes priority and goes to LSU_WAIT.
- Counters:
  - stall_cycles increments on every cycle with stall_n_pc=0, including BOOT.
  - Both counters wrap modulo 2^CNT_W without saturation.
- Error flag: err_clr clears lsu_timeout_err; a set event in the same cycle wins.
- rd_ex=0 never triggers load-use.

Decomposition:
- Shared package holds:
  - The state enum (hazard_state_e: BOOT, RUN, LSU_WAIT, REDIRECT).
  - Register-index width constant REG_ADDR_W=5.
  - INST_NOP, already present alongside the other instruction constants.
- Sub-module: hazard_perf_cnt, holding both wrapping counters and the sticky error flag. Everything else stays in the top.

Test Plan:
- Reset release:
  - Stimulus: rst_n low 3 cycles, then high.
  - Required: during reset and in the first cycle after release, flush_ifid=flush_idex=1 and stall_n_pc=0; the next cycle is RUN with all stall_n=1; stall_cycles=1.
- Load-use:
  - Stimulus: mem_read_ex=1, rd_ex=5, rs2_id=5, rs2_used_id=1.
  - Required: one cycle of stall_n_pc=0, stall_n_ifid=0, flush_idex=1. With rd_ex=0 instead: no stall.
- Jump with REDIRECT_CYCLES=1:
  - Stimulus: jump_en_ex=1 for one cycle, while a load-use condition is also present.
  - Required: flush_ifid=flush_idex=1 and no stall in that cycle; the next cycle flush_ifid=1 only; then normal; flush_events=1.
- LSU wait:
  - Stimulus: lsu_req_ex=1, lsu_ready low 4 cycles, then high.
  - Required: all stall_n=0 for 5 cycles (including the ready cycle), then RUN; stall_cycles+5; lsu_timeout_err=0.
- Timeout, with LSU_TIMEOUT=3:
  - Stimulus: lsu_ready held 0.
  - Required: return to RUN after 3 wait cycles; lsu_timeout_err=1 stays set until err_clr=1 for one cycle.
  - Stimulus: err_clr asserted together with a new timeout.
  - Required: the flag stays 1.
- Mid-wait reset and wrap:
  - Stimulus: rst_n drops during LSU_WAIT.
  - Required: immediate BOOT outputs and counters=0.
  - Stimulus: CNT_W=4, 17 stall cycles.
  - Required: stall_cycles=1.
